ebu_ctrl_hold: RTL and testbench

Per-requester address-phase holding stage that sits directly upstream of the EBU arbiter FSM, one instance each for the IFU and LSU. It forwards the requester's AHB address-phase signals to the bus multiplexer. When the arbiter asserts Save, it captures them. While Disable is asserted, it stalls the requester. On Restore, it replays the captured phase, including the burst beats, so the losing requester's transaction reaches the bus unchanged after the winner finishes.

---
 rtl/ebu_ctrl_hold_if.sv | 40 ++++
 rtl/ebu_ctrl_hold.sv | 170 +++++++++++++++++
 tb/tb_ebu_ctrl_hold.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ebu_ctrl_hold_if.sv
// Requester-side AHB address phase plus arbiter hold controls for ebu_ctrl_hold.
// Latency: none, this is a pure signal bundle.
// Backpressure: HREADYOut carries the stall back to the requester.
interface ebu_ctrl_hold_if #(
   parameter int PA_BITS = 32
);
   // arbiter controls
   logic               Save;
   logic               Restore;
   logic               Disable;
   // requester address phase
   logic [PA_BITS-1:0] HADDRIn;
   logic [2:0]         HSIZEIn;
   logic [2:0]         HBURSTIn;
   logic [1:0]         HTRANSIn;
   logic               HWRITEIn;
   logic               HREADY;
   // towards arbiter / bus mux / requester
   logic               Request;
   logic [PA_BITS-1:0] HADDROut;
   logic [2:0]         HSIZEOut;
   logic [2:0]         HBURSTOut;
   logic [1:0]         HTRANSOut;
   logic               HWRITEOut;
   logic               HREADYOut;

   // the hold stage itself
   modport slave (
      input  Save, Restore, Disable,
      input  HADDRIn, HSIZEIn, HBURSTIn, HTRANSIn, HWRITEIn, HREADY,
      output Request, HADDROut, HSIZEOut, HBURSTOut, HTRANSOut, HWRITEOut, HREADYOut
   );

   // whoever drives the stage (requester + arbiter, or a bench)
   modport master (
      output Save, Restore, Disable,
      output HADDRIn, HSIZEIn, HBURSTIn, HTRANSIn, HWRITEIn, HREADY,
      input  Request, HADDROut, HSIZEOut, HBURSTOut, HTRANSOut, HWRITEOut, HREADYOut
   );
endinterface

// File: rtl/ebu_ctrl_hold.sv
// Address-phase hold stage: passes a requester's AHB phase through, captures it on Save, replays it (with burst beats) on Restore.
// Latency: zero-cycle combinational pass-through; captured phase visible the cycle after Save.
// Backpressure: HREADYOut is forced low while held or disabled, otherwise follows HREADY.
module ebu_ctrl_hold #(
   parameter int PA_BITS = 32
) (
   input  logic            HCLK,
   input  logic            HRESETn,
   ebu_ctrl_hold_if.slave  bus
);

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;
   localparam logic [1:0] TRANS_SEQ    = 2'b11;

   typedef enum logic [1:0] {
      PASS   = 2'b00,
      HELD   = 2'b01,
      REPLAY = 2'b10
   } state_t;

   state_t             state_q, state_d;
   logic [PA_BITS-1:0] haddr_q, haddr_d;
   logic [2:0]         hsize_q, hsize_d;
   logic [2:0]         hburst_q, hburst_d;
   logic               hwrite_q, hwrite_d;
   logic [3:0]         beat_q, beat_d;
   logic               valid_q, valid_d;

   logic [4:0]         burst_beats;
   logic [3:0]         last_beat;
   logic               is_wrap;
   logic [PA_BITS-1:0] addr_incr;
   logic [PA_BITS-1:0] addr_sum;
   logic [PA_BITS-1:0] wrap_mask;
   logic [PA_BITS-1:0] addr_nxt;

   logic               request;
   logic [PA_BITS-1:0] haddr_out;
   logic [2:0]         hsize_out;
   logic [2:0]         hburst_out;
   logic [1:0]         htrans_out;
   logic               hwrite_out;
   logic               hready_out;

   // Burst geometry of the held phase: beat count, final-beat index and next beat address.
   always_comb begin
      burst_beats = 5'd1;
      case (hburst_q[2:1])
         2'b01:   burst_beats = 5'd4;
         2'b10:   burst_beats = 5'd8;
         2'b11:   burst_beats = 5'd16;
         default: burst_beats = 5'd1;
      endcase
      last_beat = 4'(burst_beats - 5'd1);
      // WRAP4/8/16 are the even, non-zero encodings
      is_wrap   = (hburst_q[0] == 1'b0) && (hburst_q != 3'b000);
      addr_incr = {{(PA_BITS-1){1'b0}}, 1'b1} << hsize_q;
      addr_sum  = haddr_q + addr_incr;
      // wrap block is (beats << size) bytes; only bits inside it take the carry
      wrap_mask = ({{(PA_BITS-5){1'b0}}, burst_beats} << hsize_q) - {{(PA_BITS-1){1'b0}}, 1'b1};
      addr_nxt  = is_wrap ? ((haddr_q & ~wrap_mask) | (addr_sum & wrap_mask)) : addr_sum;
   end

   // State and hold register; reset drops any captured transaction immediately.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= PASS;
         haddr_q  <= '0;
         hsize_q  <= '0;
         hburst_q <= '0;
         hwrite_q <= 1'b0;
         beat_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         haddr_q  <= haddr_d;
         hsize_q  <= hsize_d;
         hburst_q <= hburst_d;
         hwrite_q <= hwrite_d;
         beat_q   <= beat_d;
         valid_q  <= valid_d;
      end
   end

   // Next state, hold register updates and the combinational bus-side outputs.
   always_comb begin
      state_d    = state_q;
      haddr_d    = haddr_q;
      hsize_d    = hsize_q;
      hburst_d   = hburst_q;
      hwrite_d   = hwrite_q;
      beat_d     = beat_q;
      valid_d    = valid_q;

      request    = bus.HTRANSIn[1];
      haddr_out  = bus.HADDRIn;
      hsize_out  = bus.HSIZEIn;
      hburst_out = bus.HBURSTIn;
      htrans_out = bus.HTRANSIn;
      hwrite_out = bus.HWRITEIn;
      hready_out = bus.HREADY;

      case (state_q)
         PASS: begin
            if (bus.Disable) begin
               htrans_out = TRANS_IDLE;
               hready_out = 1'b0;
            end
            // only an active transfer is worth capturing
            if (bus.Save && bus.HTRANSIn[1]) begin
               haddr_d  = bus.HADDRIn;
               hsize_d  = bus.HSIZEIn;
               hburst_d = bus.HBURSTIn;
               hwrite_d = bus.HWRITEIn;
               beat_d   = '0;
               valid_d  = 1'b1;
               state_d  = HELD;
            end
         end

         HELD: begin
            request    = 1'b1;
            haddr_out  = haddr_q;
            hsize_out  = hsize_q;
            hburst_out = hburst_q;
            htrans_out = TRANS_IDLE;
            hwrite_out = hwrite_q;
            hready_out = 1'b0;
            if (bus.Restore && valid_q) begin
               state_d = REPLAY;
            end
         end

         REPLAY: begin
            request    = 1'b1;
            haddr_out  = haddr_q;
            hsize_out  = hsize_q;
            hburst_out = hburst_q;
            htrans_out = (beat_q == 4'd0) ? TRANS_NONSEQ : TRANS_SEQ;
            hwrite_out = hwrite_q;
            hready_out = bus.HREADY;
            // every replay cycle drives an active transfer, so HREADY alone accepts a beat
            if (bus.HREADY) begin
               if (beat_q == last_beat) begin
                  valid_d = 1'b0;
                  beat_d  = '0;
                  state_d = PASS;
               end else begin
                  beat_d  = beat_q + 4'd1;
                  haddr_d = addr_nxt;
               end
            end
         end

         default: begin
            state_d = PASS;
         end
      endcase
   end

   assign bus.Request   = request;
   assign bus.HADDROut  = haddr_out;
   assign bus.HSIZEOut  = hsize_out;
   assign bus.HBURSTOut = hburst_out;
   assign bus.HTRANSOut = htrans_out;
   assign bus.HWRITEOut = hwrite_out;
   assign bus.HREADYOut = hready_out;

endmodule

// File: tb/tb_ebu_ctrl_hold.sv
// Directed bench for ebu_ctrl_hold: pass-through, capture/hold, single/INCR4/WRAP4 replay, ignored events, async reset.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled 2 units later.
// Backpressure: HREADY wait states are driven directly from the stimulus tables.
module tb_ebu_ctrl_hold;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   logic [42:0] exp_v;

   ebu_ctrl_hold_if #(.PA_BITS(32)) bus ();

   ebu_ctrl_hold #(.PA_BITS(32)) dut (
      .HCLK    (clk),
      .HRESETn (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed output vector: {HADDR, HSIZE, HBURST, HTRANS, HWRITE, HREADYOut, Request}
   function automatic logic [42:0] obs();
      return {bus.HADDROut, bus.HSIZEOut, bus.HBURSTOut, bus.HTRANSOut,
              bus.HWRITEOut, bus.HREADYOut, bus.Request};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [31:0] a, input logic [2:0] sz, input logic [2:0] bu,
                          input logic [1:0] tr, input logic wr);
      bus.HADDRIn  = a;
      bus.HSIZEIn  = sz;
      bus.HBURSTIn = bu;
      bus.HTRANSIn = tr;
      bus.HWRITEIn = wr;
   endtask

   task automatic set_ctl(input logic sv, input logic rs, input logic ds);
      bus.Save    = sv;
      bus.Restore = rs;
      bus.Disable = ds;
   endtask

   // Save one NONSEQ phase, then Restore on the next cycle; returns one cycle into REPLAY.
   task automatic capture(input logic [31:0] a, input logic [2:0] sz, input logic [2:0] bu,
                          input logic wr);
      set_req(a, sz, bu, 2'b10, wr);
      bus.HREADY = 1'b1;
      set_ctl(1'b1, 1'b0, 1'b0);
      tick();
      set_req(32'hDEAD_0000, 3'd0, 3'd0, 2'b00, 1'b0);
      set_ctl(1'b0, 1'b1, 1'b0);
      tick();
      set_ctl(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_ctl(1'b0, 1'b0, 1'b0);
      set_req(32'h0000_0055, 3'd1, 3'd0, 2'b10, 1'b0);
      bus.HREADY = 1'b1;
      #2;
      exp_v = {32'h0000_0055, 3'd1, 3'd0, 2'b10, 1'b0, 1'b1, 1'b1};
      tests++;
      if (obs() !== exp_v) begin
         fails++;
         $display("FAIL reset_passthru got %h need %h", obs(), exp_v);
      end
      bus.HTRANSIn = 2'b00;
      bus.HREADY   = 1'b0;
      #1;
      exp_v = {32'h0000_0055, 3'd1, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0};
      tests++;
      if (obs() !== exp_v) begin
         fails++;
         $display("FAIL reset_idle got %h need %h", obs(), exp_v);
      end
      // Save while in reset must not capture
      bus.HTRANSIn = 2'b10;
      bus.HREADY   = 1'b1;
      bus.Save     = 1'b1;
      tick();
      tick();
      bus.Save = 1'b0;
      rst_n    = 1'b1;
      #2;
      exp_v = {32'h0000_0055, 3'd1, 3'd0, 2'b10, 1'b0, 1'b1, 1'b1};
      tests++;
      if (obs() !== exp_v) begin
         fails++;
         $display("FAIL reset_no_capture got %h need %h", obs(), exp_v);
      end
   endtask

   task automatic test_pass();
      tick();
      set_req(32'h0000_1000, 3'd2, 3'd0, 2'b10, 1'b1);
      bus.HREADY = 1'b1;
      set_ctl(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         #2;
         exp_v = {32'h0000_1000, 3'd2, 3'd0, 2'b10, 1'b1, 1'b1, 1'b1};
         tests++;
         if (obs() !== exp_v) begin
            fails++;
            $display("FAIL pass_mirror[%0d] got %h need %h", i, obs(), exp_v);
         end
         tick();
      end
      bus.HREADY = 1'b0;
      #2;
      exp_v = {32'h0000_1000, 3'd2, 3'd0, 2'b10, 1'b1, 1'b0, 1'b1};
      tests++;
      if (obs() !== exp_v) begin
         fails++;
         $display("FAIL pass_hready_low got %h need %h", obs(), exp_v);
      end
      tick();
      bus.HREADY  = 1'b1;
      bus.Disable = 1'b1;
      #2;
      exp_v = {32'h0000_1000, 3'd2, 3'd0, 2'b00, 1'b1, 1'b0, 1'b1};
      tests++;
      if (obs() !== exp_v) begin
         fails++;
         $display("FAIL pass_disable got %h need %h", obs(), exp_v);
      end
      tick();
      // Disable must not have captured: new inputs show straight through
      bus.Disable = 1'b0;
      set_req(32'h0000_1100, 3'd1, 3'd3, 2'b11, 1'b0);
      #2;
      exp_v = {32'h0000_1100, 3'd1, 3'd3, 2'b11, 1'b0, 1'b1, 1'b1};
      tests++;
      if (obs() !== exp_v) begin
         fails++;
         $display("FAIL pass_after_disable got %h need %h", obs(), exp_v);
      end
   endtask

   task automatic test_ignored();
      tick();
      set_req(32'h0000_1234, 3'd2, 3'd0, 2'b00, 1'b1);
      bus.HREADY = 1'b1;
      set_ctl(1'b1, 1'b0, 1'b0);
      #2;
      exp_v = {32'h0000_1234, 3'd2, 3'd0, 2'b00, 1'b1, 1'b1, 1'b0};
      tests++;
      if (obs() !== exp_v) begin
         fails++;
         $display("FAIL save_idle_cycle got %h need %h", obs(), exp_v);
      end
      tick();
      set_ctl(1'b0, 1'b0, 1'b0);
      bus.HTRANSIn = 2'b10;
      #2;
      exp_v = {32'h0000_1234, 3'd2, 3'd0, 2'b10, 1'b1, 1'b1, 1'b1};
      tests++;
      if (obs() !== exp_v) begin
         fails++;
         $display("FAIL save_idle_ignored got %h need %h", obs(), exp_v);
      end
      // Restore while passing through is ignored
      bus.Restore = 1'b1;
      tick();
      bus.Restore = 1'b0;
      bus.HADDRIn = 32'h0000_1238;
      #2;
      exp_v = {32'h0000_1238, 3'd2, 3'd0, 2'b10, 1'b1, 1'b1, 1'b1};
      tests++;
      if (obs() !== exp_v) begin
         fails++;
         $display("FAIL restore_in_pass got %h need %h", obs(), exp_v);
      end
   endtask

   task automatic test_single();
      tick();
      set_req(32'h0000_2004, 3'd2, 3'd0, 2'b10, 1'b1);
      bus.HREADY = 1'b1;
      set_ctl(1'b1, 1'b0, 1'b0);
      #2;
      exp_v = {32'h0000_2004, 3'd2, 3'd0, 2'b10, 1'b1, 1'b1, 1'b1};
      tests++;
      if (obs() !== exp_v) begin
         fails++;
         $display("FAIL single_save_cycle got %h need %h", obs(), exp_v);
      end
      tick();
      // three held cycles; a second Save lands in the middle, Restore on the last
      set_req(32'h0000_9990, 3'd0, 3'd3, 2'b10, 1'b0);
      for (int i = 0; i < 3; i++) begin
         set_ctl((i == 1), (i == 2), 1'b1);
         #2;
         exp_v = {32'h0000_2004, 3'd2, 3'd0, 2'b00, 1'b1, 1'b0, 1'b1};
         tests++;
         if (obs() !== exp_v) begin
            fails++;
            $display("FAIL single_held[%0d] got %h need %h", i, obs(), exp_v);
         end
         tick();
      end
      set_ctl(1'b0, 1'b0, 1'b0);
      #2;
      exp_v = {32'h0000_2004, 3'd2, 3'd0, 2'b10, 1'b1, 1'b1, 1'b1};
      tests++;
      if (obs() !== exp_v) begin
         fails++;
         $display("FAIL single_replay got %h need %h", obs(), exp_v);
      end
      tick();
      bus.HTRANSIn = 2'b00;
      #2;
      exp_v = {32'h0000_9990, 3'd0, 3'd3, 2'b00, 1'b0, 1'b1, 1'b0};
      tests++;
      if (obs() !== exp_v) begin
         fails++;
         $display("FAIL single_back_to_pass got %h need %h", obs(), exp_v);
      end
   endtask

   task automatic test_incr4_wait();
      logic [31:0] ea [0:4];
      logic [1:0]  et [0:4];
      logic        hr [0:4];
      ea = '{32'h0000_3000, 32'h0000_3004, 32'h0000_3008, 32'h0000_3008, 32'h0000_300C};
      et = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
      hr = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      tick();
      capture(32'h0000_3000, 3'd2, 3'b011, 1'b0);
      for (int i = 0; i < 5; i++) begin
         bus.HREADY = hr[i];
         #2;
         exp_v = {ea[i], 3'd2, 3'b011, et[i], 1'b0, hr[i], 1'b1};
         tests++;
         if (obs() !== exp_v) begin
            fails++;
            $display("FAIL incr4_beat[%0d] got %h need %h", i, obs(), exp_v);
         end
         tick();
      end
      bus.HREADY = 1'b1;
      #2;
      exp_v = {32'hDEAD_0000, 3'd0, 3'd0, 2'b00, 1'b0, 1'b1, 1'b0};
      tests++;
      if (obs() !== exp_v) begin
         fails++;
         $display("FAIL incr4_exit got %h need %h", obs(), exp_v);
      end
   endtask

   task automatic test_wrap4();
      logic [31:0] ea [0:3];
      ea = '{32'h0000_4008, 32'h0000_400C, 32'h0000_4000, 32'h0000_4004};
      tick();
      capture(32'h0000_4008, 3'd2, 3'b010, 1'b1);
      for (int i = 0; i < 4; i++) begin
         #2;
         exp_v = {ea[i], 3'd2, 3'b010, (i == 0) ? 2'b10 : 2'b11, 1'b1, 1'b1, 1'b1};
         tests++;
         if (obs() !== exp_v) begin
            fails++;
            $display("FAIL wrap4_beat[%0d] got %h need %h", i, obs(), exp_v);
         end
         tick();
      end
      #2;
      exp_v = {32'hDEAD_0000, 3'd0, 3'd0, 2'b00, 1'b0, 1'b1, 1'b0};
      tests++;
      if (obs() !== exp_v) begin
         fails++;
         $display("FAIL wrap4_exit got %h need %h", obs(), exp_v);
      end
   endtask

   task automatic test_reset_mid_replay();
      tick();
      capture(32'h0000_5000, 3'd2, 3'b101, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #2;
         exp_v = {32'h0000_5000 + 32'(i * 4), 3'd2, 3'b101, (i == 0) ? 2'b10 : 2'b11, 1'b0, 1'b1, 1'b1};
         tests++;
         if (obs() !== exp_v) begin
            fails++;
            $display("FAIL incr8_beat[%0d] got %h need %h", i, obs(), exp_v);
         end
         if (i < 3) tick();
      end
      // asynchronous reset in the middle of beat 3
      rst_n = 1'b0;
      #1;
      exp_v = {32'hDEAD_0000, 3'd0, 3'd0, 2'b00, 1'b0, 1'b1, 1'b0};
      tests++;
      if (obs() !== exp_v) begin
         fails++;
         $display("FAIL incr8_async_reset got %h need %h", obs(), exp_v);
      end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #2;
         tests++;
         if (obs() !== exp_v) begin
            fails++;
            $display("FAIL incr8_no_more_beats[%0d] got %h need %h", i, obs(), exp_v);
         end
         tick();
      end
      set_req(32'h0000_6000, 3'd2, 3'b101, 2'b10, 1'b0);
      #2;
      exp_v = {32'h0000_6000, 3'd2, 3'b101, 2'b10, 1'b0, 1'b1, 1'b1};
      tests++;
      if (obs() !== exp_v) begin
         fails++;
         $display("FAIL incr8_reissue got %h need %h", obs(), exp_v);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      test_reset();
      test_pass();
      test_ignored();
      test_single();
      test_incr4_wait();
      test_wrap4();
      test_reset_mid_replay();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
